res_station_array: RTL
======================

// Module: res_station_array
// PURPOSE
//  Multi-entry reservation station for one functional unit, parametrised in depth and widths.
//  Dispatch writes an instruction into a free entry. Entries snoop the CDB to capture missing
//  operands. The oldest entry with both operands valid is offered to the FU on an issue handshake.
//  Sits between the dispatch/rename stage and an ALU, sharing the CDB with the ROB.
// PARAMETERS
//  DEPTH       4   number of entries (power of 2, >=2)
//  DATA_WIDTH  16  operand width
//  TAG_WIDTH   3   ROB tag width (Qj/Qk/dest)
//  OP_WIDTH    4   opcode width (lc3b_opcode)
// PORTS
//  clk           in   1                  clock; all state updates on rising edge
//  flush         in   1                  synchronous active-high reset/flush; clears every entry
//  disp_valid    in   1                  dispatch request
//  disp_ready    out  1                  entry available (= !full)
//  op_in         in   OP_WIDTH           opcode
//  Vj_in,Vk_in   in   DATA_WIDTH         operand values
//  Vj_valid_in   in   1                  Vj_in holds real data; else wait on Qj_in
//  Vk_valid_in   in   1                  same for Vk
//  Qj_in,Qk_in   in   TAG_WIDTH          producer tags
//  dest_in       in   TAG_WIDTH          ROB destination tag
//  cdb_valid     in   1                  CDB broadcast valid
//  cdb_tag       in   TAG_WIDTH          CDB producer tag
//  cdb_data      in   DATA_WIDTH         CDB value
//  issue_valid   out  1                  a ready entry is presented
//  issue_ready   in   1                  FU accepts this cycle
//  issue_op      out  OP_WIDTH           selected opcode
//  issue_Vj/Vk   out  DATA_WIDTH         selected operands
//  issue_dest    out  TAG_WIDTH          selected destination tag
//  count         out  $clog2(DEPTH)+1    busy entries
//  full          out  1                  count == DEPTH
// BEHAVIOUR
//  Entry state: busy, op, Vj, Vj_valid, Qj, Vk, Vk_valid, Qk, dest, age[$clog2(DEPTH)-1:0].
//  Reset/flush: all entry fields cleared.
//   Next cycle: count=0, full=0, disp_ready=1, issue_valid=0, all issue_* outputs 0.
//   Flush dominates same-cycle dispatch, CDB and issue; none of them take effect.
//  Dispatch:
//   - Accepted when disp_valid && disp_ready; disp_ready is from current state only.
//   - A slot freed by a same-cycle issue is not reusable that cycle.
//   - Writes the lowest-index non-busy entry.
//  Dispatch/CDB bypass:
//   - If cdb_valid, an incoming operand is invalid, and its Q equals cdb_tag, store cdb_data.
//   - That operand is stored with valid=1.
//  Wakeup:
//   - On cdb_valid, every busy entry with !Vj_valid && Qj==cdb_tag loads Vj=cdb_data, Vj_valid=1.
//   - Vk is handled the same way; one broadcast may wake both operands of an entry.
//   - Non-busy entries ignore the CDB.
//  Ready = busy && Vj_valid && Vk_valid, evaluated on registered state. There is no CDB-to-issue
//   combinational path: an entry woken at edge N can issue in cycle N+1 at earliest.
//  Select and outputs:
//   - Among ready entries, pick the smallest age. Ages are unique among busy entries; 0 = oldest.
//   - issue_* outputs are driven combinationally from the selected entry.
//   - When no entry is ready, issue_valid=0 and issue_* = 0.
//  Issue handshake:
//   - Entry is freed when issue_valid && issue_ready; busy clears at that edge.
//   - Held stable while issue_valid && !issue_ready, unless an older entry becomes ready first.
//  Age:
//   - Issue of the entry with age A: each remaining busy entry with age > A decrements by 1.
//   - A new entry gets age = count - (issue fire ? 1 : 0), i.e. youngest.
//  Counts:
//   - count' = count + dispatch_fire - issue_fire; a simultaneous dispatch and issue leaves count unchanged.
//   - full = (count == DEPTH).
//   - Dispatch while full is ignored with no state change; dispatch_fire is impossible when full.
// TESTING
//  1 Flush/reset:
//     flush=1 one cycle -> count=0, full=0, disp_ready=1, issue_valid=0, issue_Vj=0.
//  2 Ready dispatch:
//     op=ADD, Vj=0x0005, Vk=0x0003 (both valid), dest=2 at edge 0.
//     -> issue_valid=1 cycle 1 with issue_Vj=0x0005, issue_dest=2.
//     issue_ready=1 -> count 0 at edge 2.
//  3 Wakeup:
//     dispatch Vj valid 0x0010, Qk=5 invalid -> issue_valid stays 0.
//     cdb_valid, tag 5, data 0x00FF at edge N -> issue_valid=1 in cycle N+1 with issue_Vk=0x00FF.
//  4 Bypass:
//     dispatch Qj=4 invalid while cdb_valid, tag 4, data 0x1234 same cycle
//     -> entry stored with Vj=0x1234, valid; issues next cycle.
//  5 Age order:
//     dispatch A (waits tag 1), then B (ready), then C (ready) with issue_ready=0 -> B selected.
//     CDB tag 1 -> A selected next cycle (oldest).
//     Accept all -> order B, A, C, or A, B, C depending on handshake timing; check age-min rule every cycle.
//  6 Full/flush:
//     fill 4 entries none ready -> full=1, disp_ready=0; 5th dispatch ignored (count stays 4).
//     flush asserted with disp_valid=1 and cdb_valid=1 -> count=0, no entry written.

Source files
------------

// File: rtl/res_station_array.sv
// Reservation station for one functional unit: dispatch into free entries, CDB wakeup,
// oldest-ready selection and issue handshake.
module res_station_array #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 3,
    parameter int OP_WIDTH   = 4
) (
    input  logic                       clk,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [OP_WIDTH-1:0]        op_in,
    input  logic [DATA_WIDTH-1:0]      Vj_in,
    input  logic [DATA_WIDTH-1:0]      Vk_in,
    input  logic                       Vj_valid_in,
    input  logic                       Vk_valid_in,
    input  logic [TAG_WIDTH-1:0]       Qj_in,
    input  logic [TAG_WIDTH-1:0]       Qk_in,
    input  logic [TAG_WIDTH-1:0]       dest_in,
    input  logic                       cdb_valid,
    input  logic [TAG_WIDTH-1:0]       cdb_tag,
    input  logic [DATA_WIDTH-1:0]      cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [OP_WIDTH-1:0]        issue_op,
    output logic [DATA_WIDTH-1:0]      issue_Vj,
    output logic [DATA_WIDTH-1:0]      issue_Vk,
    output logic [TAG_WIDTH-1:0]       issue_dest,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]      busy_r;
    logic [DEPTH-1:0]      vj_valid_r;
    logic [DEPTH-1:0]      vk_valid_r;
    logic [OP_WIDTH-1:0]   op_r   [DEPTH];
    logic [DATA_WIDTH-1:0] vj_r   [DEPTH];
    logic [DATA_WIDTH-1:0] vk_r   [DEPTH];
    logic [TAG_WIDTH-1:0]  qj_r   [DEPTH];
    logic [TAG_WIDTH-1:0]  qk_r   [DEPTH];
    logic [TAG_WIDTH-1:0]  dest_r [DEPTH];
    logic [AW-1:0]         age_r  [DEPTH];
    logic [CW-1:0]         count_r;

    logic [DEPTH-1:0] ready_s;
    logic             sel_found_s;
    logic [AW-1:0]    sel_idx_s;
    logic [AW-1:0]    sel_age_s;
    logic [AW-1:0]    free_idx_s;
    logic             disp_fire_s;
    logic             issue_fire_s;
    logic             byp_j_s;
    logic             byp_k_s;
    logic [AW-1:0]    new_age_s;

    assign ready_s      = busy_r & vj_valid_r & vk_valid_r;
    assign full         = (count_r == CW'(DEPTH));
    assign disp_ready   = !full;
    assign count        = count_r;
    assign disp_fire_s  = disp_valid && !full;
    assign issue_fire_s = sel_found_s && issue_ready;
    assign byp_j_s      = cdb_valid && !Vj_valid_in && (Qj_in == cdb_tag);
    assign byp_k_s      = cdb_valid && !Vk_valid_in && (Qk_in == cdb_tag);
    // A slot freed this cycle is not reused, so the newcomer lands behind the survivors.
    assign new_age_s    = AW'(count_r - CW'(issue_fire_s));

    // Oldest-ready select: smallest age among ready entries.
    always_comb begin
        logic take_v;
        take_v      = 1'b0;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        sel_age_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            take_v      = ready_s[i] && (!sel_found_s || (age_r[i] < sel_age_s));
            sel_idx_s   = take_v ? AW'(i) : sel_idx_s;
            sel_age_s   = take_v ? age_r[i] : sel_age_s;
            sel_found_s = sel_found_s || take_v;
        end
    end

    // Lowest-index free slot for dispatch.
    always_comb begin
        free_idx_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx_s = busy_r[i] ? free_idx_s : AW'(i);
        end
    end

    // Issue outputs follow the selected entry, zero when nothing is ready.
    always_comb begin
        issue_valid = sel_found_s;
        if (sel_found_s) begin
            issue_op   = op_r[sel_idx_s];
            issue_Vj   = vj_r[sel_idx_s];
            issue_Vk   = vk_r[sel_idx_s];
            issue_dest = dest_r[sel_idx_s];
        end else begin
            issue_op   = '0;
            issue_Vj   = '0;
            issue_Vk   = '0;
            issue_dest = '0;
        end
    end

    // Entry state: flush, issue release, CDB wakeup, age compaction and dispatch write.
    always_ff @(posedge clk) begin
        if (flush) begin
            count_r    <= '0;
            busy_r     <= '0;
            vj_valid_r <= '0;
            vk_valid_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_r[i]   <= '0;
                vj_r[i]   <= '0;
                vk_r[i]   <= '0;
                qj_r[i]   <= '0;
                qk_r[i]   <= '0;
                dest_r[i] <= '0;
                age_r[i]  <= '0;
            end
        end else begin
            count_r <= count_r + CW'(disp_fire_s) - CW'(issue_fire_s);
            for (int i = 0; i < DEPTH; i++) begin
                if (issue_fire_s && (sel_idx_s == AW'(i))) begin
                    busy_r[i] <= 1'b0;
                end else if (busy_r[i]) begin
                    if (cdb_valid && !vj_valid_r[i] && (qj_r[i] == cdb_tag)) begin
                        vj_r[i]       <= cdb_data;
                        vj_valid_r[i] <= 1'b1;
                    end
                    if (cdb_valid && !vk_valid_r[i] && (qk_r[i] == cdb_tag)) begin
                        vk_r[i]       <= cdb_data;
                        vk_valid_r[i] <= 1'b1;
                    end
                    if (issue_fire_s && (age_r[i] > sel_age_s)) begin
                        age_r[i] <= age_r[i] - AW'(1'b1);
                    end
                end else if (disp_fire_s && (free_idx_s == AW'(i))) begin
                    busy_r[i]     <= 1'b1;
                    op_r[i]       <= op_in;
                    vj_r[i]       <= byp_j_s ? cdb_data : Vj_in;
                    vk_r[i]       <= byp_k_s ? cdb_data : Vk_in;
                    vj_valid_r[i] <= Vj_valid_in || byp_j_s;
                    vk_valid_r[i] <= Vk_valid_in || byp_k_s;
                    qj_r[i]       <= Qj_in;
                    qk_r[i]       <= Qk_in;
                    dest_r[i]     <= dest_in;
                    age_r[i]      <= new_age_s;
                end
            end
        end
    end
endmodule
